// File: rtl/simple_bus_responder_pkg.sv
// Shared types and constants for simple_bus_responder.
package simple_bus_responder_pkg;

    // Width of the wait-state counter; WAIT_CYCLES must fit in it.
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/simple_bus_responder_mem.sv
// Word storage for simple_bus_responder: one synchronous access port with a registered
// read result, and every word cleared by the asynchronous reset.
module simple_bus_responder_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_acc,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_in_range;

    // Guards non-power-of-two depths where the low index bits can exceed DEPTH-1.
    assign w_in_range = (32'(i_idx) < DEPTH);

    // Storage write and read-result capture; the result is zero for writes and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else if (i_acc) begin
            if (i_we && w_in_range) begin
                r_mem[i_idx] <= i_wdata;
            end
            r_rdata <= (i_re && w_in_range) ? r_mem[i_idx] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/simple_bus_responder.sv
// Single-outstanding request/response responder with fixed wait states.
// Optional feature: define SIMPLE_BUS_RESPONDER_ERR_EN to flag addresses >= DEPTH as
// errors; otherwise the address wraps modulo DEPTH and rsp_error is always 0.
import simple_bus_responder_pkg::*;

module simple_bus_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_rsp_valid;
    logic               r_rsp_error;

    logic               w_access;
    logic               w_acc_write;
    logic [ADDR_W-1:0]  w_acc_addr;
    logic [DATA_W-1:0]  w_acc_wdata;
    logic               w_err;

    // Held low during reset so nothing is accepted while the block is being cleared.
    assign req_ready = rst_n && (r_state == ST_IDLE);

    // With no wait states the access happens on the accept edge, straight from the inputs.
    assign w_access    = (WAIT_CYCLES == 0) ? (req_valid && req_ready)
                                            : ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));
    assign w_acc_write = (WAIT_CYCLES == 0) ? req_write : r_write;
    assign w_acc_addr  = (WAIT_CYCLES == 0) ? req_addr  : r_addr;
    assign w_acc_wdata = (WAIT_CYCLES == 0) ? req_wdata : r_wdata;

`ifdef SIMPLE_BUS_RESPONDER_ERR_EN
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    assign w_err = ({1'b0, w_acc_addr} >= DEPTH_EXT);
`else
    // Address wraps to its low index bits; the error register folds to a constant 0.
    assign w_err = 1'b0;
`endif

    generate
        if (IDX_W < ADDR_W) begin : g_addr_hi
            logic w_unused_addr;
            assign w_unused_addr = ^w_acc_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    simple_bus_responder_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_acc   (w_access),
        .i_we    (w_acc_write && !w_err),
        .i_re    (!w_acc_write && !w_err),
        .i_idx   (w_acc_addr[IDX_W-1:0]),
        .i_wdata (w_acc_wdata),
        .o_rdata (rsp_rdata)
    );

    // Request/wait/response sequencing with registered response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= w_err;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= ST_RESP;
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= w_err;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_error <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_error = r_rsp_error;

endmodule

// File: doc/simple_bus_responder.md
SIMPLE_BUS_RESPONDER -- requirements
Module: simple_bus_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, request address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16, the number of storage words (1..2^ADDR_W).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2, the fixed wait states between request accept and response (0..255).
REQ-005 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port req_valid  input  1  master presents a request.
REQ-008 The block SHALL have port req_ready  output  1  responder accepts a request.
REQ-009 The block SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr  input  ADDR_W  word address.
REQ-011 The block SHALL have port req_wdata  input  DATA_W  write data.
REQ-012 The block SHALL have port rsp_valid  output  1  response available.
REQ-013 The block SHALL have port rsp_ready  input  1  master accepts the response.
REQ-014 The block SHALL have port rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-015 The block SHALL have port rsp_error  output  1  access error flag.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-017 In IDLE, req_ready SHALL be 1; in WAIT and RESP it SHALL be 0, so at most one request is outstanding.
REQ-018 A request is accepted on a rising edge with req_valid & req_ready; req_write, req_addr and req_wdata SHALL be captured on that edge.
REQ-019 After accept, the FSM SHALL enter WAIT with the wait counter loaded to WAIT_CYCLES, or enter RESP directly when WAIT_CYCLES = 0.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when it reaches 1, the FSM SHALL perform the access and enter RESP on that edge.
REQ-021 Given accept at edge N, rsp_valid SHALL be 1 in the cycle after edge N+1+WAIT_CYCLES-1 (WAIT_CYCLES+1 cycles total latency).
REQ-022 The write SHALL update storage on the same edge the FSM enters RESP, and it SHALL update storage exactly once per request.
REQ-023 Read data SHALL be sampled from storage on the same edge and held stable in rsp_rdata while rsp_valid = 1.
REQ-024 rsp_valid, rsp_rdata and rsp_error SHALL stay stable in RESP until rsp_ready = 1; on that edge the FSM SHALL return to IDLE and rsp_valid SHALL drop.
REQ-025 req_valid asserted during WAIT or RESP SHALL be ignored (not accepted) until IDLE.
REQ-026 Read-after-write to the same address SHALL return the newly written data.
REQ-027 The wait counter SHALL be 8 bits wide; the storage index SHALL be clog2(DEPTH) bits wide.

Reset
REQ-028 While rst_n = 0: FSM = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, and all storage words = 0.
REQ-029 req_ready SHALL be 0 while rst_n = 0, and 1 in the first cycle after release.
REQ-030 Reset asserted in WAIT or RESP SHALL abort the transaction immediately, with no pending write performed and no response issued.

Configuration
REQ-031 When SIMPLE_BUS_RESPONDER_ERR_EN is defined, req_addr >= DEPTH SHALL produce rsp_error = 1 and rsp_rdata = 0, with no storage write; latency is unchanged.
REQ-032 When SIMPLE_BUS_RESPONDER_ERR_EN is undefined, the address SHALL be taken modulo DEPTH (low index bits), and rsp_error SHALL be tied to 0.

Structure
REQ-033 The package simple_bus_responder_pkg SHALL hold the FSM state enum (ST_IDLE, ST_WAIT, ST_RESP) and the WAIT counter width constant.
REQ-034 Storage SHALL be a sub-module simple_bus_responder_mem with one synchronous write/read port and asynchronous reset-to-zero.

Verification
REQ-035 Reset release, then write addr 0x03 data 0xDEADBEEF and read addr 0x03 -> read response rsp_rdata = 0xDEADBEEF, rsp_error = 0.
REQ-036 WAIT_CYCLES = 2: accept at cycle 10 -> rsp_valid first high at cycle 13; WAIT_CYCLES = 0: accept at cycle 10 -> rsp_valid high at cycle 11.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a second req_valid is not accepted until the cycle after the rsp_ready handshake.
REQ-038 With ERR_EN defined, DEPTH = 16: write 0x11 to addr 0x20 -> rsp_error = 1, and a read of addr 0x00 returns 0; without ERR_EN, the same write lands at addr 0x00 and reads back 0x11.
REQ-039 rst_n pulsed low during WAIT of a write 0x55 to addr 0x05 -> no response is issued, and a subsequent read of addr 0x05 returns 0.
